keypad_emulator: RTL

Synthesizable 4x4 matrix-keypad model: the responder end of the keypad scan interface used by the calculator input unit. It accepts key codes from a host (test sequencer or soft controller) into a small FIFO. It replays each code as a timed physical press, with optional contact chatter, by pulling the addressed row low whenever the scanner drives that key's column low. It is used for hardware-in-loop and regression of the keypad input path without a physical keypad.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/key_fifo.sv | 65 ++++++
 rtl/keypad_emulator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator and the keypad input unit:
// key-code field layout, emulator FSM states and the idle row pattern.
package keypad_pkg;

  // Key code layout: code[3:2] = row index, code[1:0] = column index
  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  // Row lines are active-low; nothing pressed means all ones
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } kp_state_e;

  // Down-counter load value for a phase of 'cycles' cycles; a zero-length
  // phase is stretched to one cycle so the FSM always makes progress.
  function automatic logic [31:0] phase_load(input int cycles);
    if (cycles <= 0) begin
      return 32'd0;
    end else begin
      return 32'(cycles - 1);
    end
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous key-code FIFO with occupancy count. A push is refused while
// full (judged on the pre-pop count); a pop is ignored while empty.
module key_fifo
  import keypad_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array: written on accepted pushes only, contents need no reset
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks push minus pop
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad responder: replays queued key codes as timed presses
// (optionally with contact chatter) by pulling the addressed row low while
// the scanner strobes that key's column.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int PRESS_CYCLES  = 5000000,
  parameter int GAP_CYCLES    = 2500000,
  parameter int BOUNCE_CYCLES = 0,
  parameter int BOUNCE_TOGGLE = 16
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  output logic                          key_ready,
  input  logic [3:0]                    col,
  output logic [3:0]                    row,
  output logic                          key_active,
  output logic                          press_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [31:0] PRESS_LOAD  = phase_load(PRESS_CYCLES);
  localparam logic [31:0] GAP_LOAD    = phase_load(GAP_CYCLES);
  localparam logic [31:0] BOUNCE_LOAD = phase_load(BOUNCE_CYCLES);
  localparam logic [31:0] TOG_LOAD    = phase_load(BOUNCE_TOGGLE);
  localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES > 0);

  kp_state_e   r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_tog;
  logic        r_contact;
  logic [1:0]  r_cur_row;
  logic [1:0]  r_cur_col;
  logic        r_key_active;
  logic        r_press_done;

  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic [3:0]  w_code;
  logic [31:0] w_tog_next;
  logic        w_contact_bounce;
  logic [3:0]  w_row;

  // The FSM only pops while idle, and only when there is something to pop
  assign w_pop = (r_state == ST_IDLE) && !w_empty;

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clock   (clock),
    .clear   (clear),
    .i_push  (key_valid),
    .i_wdata (key_code),
    .i_pop   (w_pop),
    .o_rdata (w_code),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign key_ready  = !w_full;
  assign key_active = r_key_active;
  assign press_done = r_press_done;
  assign row        = w_row;

  // Chatter generator: contact flips each time the toggle counter expires
  always_comb begin
    w_tog_next       = r_tog - 32'd1;
    w_contact_bounce = r_contact;
    if (r_tog == 32'd0) begin
      w_tog_next       = TOG_LOAD;
      w_contact_bounce = ~r_contact;
    end else begin
      w_tog_next       = r_tog - 32'd1;
      w_contact_bounce = r_contact;
    end
  end

  // Row drive: zero-latency response to the column strobe of the current key
  always_comb begin
    w_row = ROW_IDLE;
    if (r_contact && (col[r_cur_col] == 1'b0)) begin
      w_row[r_cur_row] = 1'b0;
    end else begin
      w_row = ROW_IDLE;
    end
  end

  // Press sequencer: one shared down-counter times every phase
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 32'd0;
      r_tog        <= 32'd0;
      r_contact    <= 1'b0;
      r_cur_row    <= 2'd0;
      r_cur_col    <= 2'd0;
      r_key_active <= 1'b0;
      r_press_done <= 1'b0;
    end else begin
      r_press_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cur_row    <= w_code[ROW_MSB:ROW_LSB];
            r_cur_col    <= w_code[COL_MSB:COL_LSB];
            r_contact    <= 1'b1;
            r_key_active <= 1'b1;
            r_tog        <= TOG_LOAD;
            if (HAS_BOUNCE) begin
              r_state <= ST_BOUNCE_IN;
              r_cnt   <= BOUNCE_LOAD;
            end else begin
              r_state <= ST_HOLD;
              r_cnt   <= PRESS_LOAD;
            end
          end
        end
        ST_BOUNCE_IN: begin
          if (r_cnt == 32'd0) begin
            r_state   <= ST_HOLD;
            r_cnt     <= PRESS_LOAD;
            r_contact <= 1'b1;
          end else begin
            r_cnt     <= r_cnt - 32'd1;
            r_tog     <= w_tog_next;
            r_contact <= w_contact_bounce;
          end
        end
        ST_HOLD: begin
          if (r_cnt == 32'd0) begin
            r_contact <= 1'b0;
            r_tog     <= TOG_LOAD;
            if (HAS_BOUNCE) begin
              r_state <= ST_BOUNCE_OUT;
              r_cnt   <= BOUNCE_LOAD;
            end else begin
              r_state      <= ST_GAP;
              r_cnt        <= GAP_LOAD;
              r_key_active <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        ST_BOUNCE_OUT: begin
          if (r_cnt == 32'd0) begin
            r_state      <= ST_GAP;
            r_cnt        <= GAP_LOAD;
            r_contact    <= 1'b0;
            r_key_active <= 1'b0;
          end else begin
            r_cnt     <= r_cnt - 32'd1;
            r_tog     <= w_tog_next;
            r_contact <= w_contact_bounce;
          end
        end
        ST_GAP: begin
          if (r_cnt == 32'd0) begin
            r_state      <= ST_IDLE;
            r_press_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cnt        <= 32'd0;
          r_contact    <= 1'b0;
          r_key_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
